mult_div: RTL and testbench

MULT_DIV -- requirements
Module: mult_div

---
 rtl/mult_div_if.sv | 21 ++
 rtl/mult_div.sv | 108 ++++++++++
 tb/tb_mult_div.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
// Request/response bundle between the E stage and the HI/LO multiply-divide unit.
interface mult_div_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  op;
    logic        start;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output A, B, op, start, cancel,
        input  busy, hi, lo
    );

    modport slave (
        input  A, B, op, start, cancel,
        output busy, hi, lo
    );
endinterface

// File: rtl/mult_div.sv
// MIPS-style HI/LO unit: 5-cycle mult/multu, 10-cycle div/divu, single-cycle mthi/mtlo.
module mult_div (
    input  logic      clk,
    input  logic      reset,
    mult_div_if.slave bus
);
    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    typedef enum logic {StIdle, StRun} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_q, lo_q;

    logic        accept;
    logic        signed_op, a_neg, b_neg, res_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag;
    logic [63:0] prod_mag, prod;
    logic [31:0] quot, rem;
    logic        is_mul_q;

    always_comb begin
        accept = bus.start && !bus.cancel && (state_q == StIdle);
    end

    // Sign-magnitude datapath shared by signed and unsigned forms; this also gives
    // 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
    always_comb begin
        signed_op = (op_q == OpMult) || (op_q == OpDiv);
        is_mul_q  = (op_q == OpMult) || (op_q == OpMultu);
        a_neg     = signed_op && a_q[31];
        b_neg     = signed_op && b_q[31];
        res_neg   = a_neg ^ b_neg;
        a_mag     = a_neg ? (~a_q + 32'd1) : a_q;
        b_mag     = b_neg ? (~b_q + 32'd1) : b_q;
        prod_mag  = {32'd0, a_mag} * {32'd0, b_mag};
        prod      = res_neg ? (~prod_mag + 64'd1) : prod_mag;
        q_mag     = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
        r_mag     = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
        quot      = res_neg ? (~q_mag + 32'd1) : q_mag;
        rem       = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        case (bus.op)
                            OpMult, OpMultu: begin
                                state_q <= StRun;
                                cnt_q   <= 4'd5;
                                op_q    <= bus.op;
                                a_q     <= bus.A;
                                b_q     <= bus.B;
                            end
                            OpDiv, OpDivu: begin
                                state_q <= StRun;
                                cnt_q   <= 4'd10;
                                op_q    <= bus.op;
                                a_q     <= bus.A;
                                b_q     <= bus.B;
                            end
                            OpMthi:  hi_q <= bus.A;
                            OpMtlo:  lo_q <= bus.A;
                            default: ;
                        endcase
                    end
                end
                StRun: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= StIdle;
                        cnt_q   <= 4'd0;
                        if (is_mul_q) begin
                            {hi_q, lo_q} <= prod;
                        end else if (b_q != 32'd0) begin
                            // Divide by zero leaves HI/LO untouched.
                            lo_q <= quot;
                            hi_q <= rem;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: directed scenarios plus randomized ops vs a reference model.
module tb_mult_div;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [31:0] exp_hi, exp_lo;

    mult_div_if bus ();

    mult_div dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain SV arithmetic on the architectural HI/LO and the documented latencies.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit cxl, output int lat);
        longint sa, sb, q, r;
        logic [63:0] p;
        lat = 0;
        if (cxl) return;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin
                p = 64'(sa * sb);
                {exp_hi, exp_lo} = p;
                lat = 5;
            end
            3'd2: begin
                p = {32'd0, a} * {32'd0, b};
                {exp_hi, exp_lo} = p;
                lat = 5;
            end
            3'd3: begin
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    exp_lo = q[31:0];
                    exp_hi = r[31:0];
                end
                lat = 10;
            end
            3'd4: begin
                if (b != 0) begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
                lat = 10;
            end
            3'd5: exp_hi = a;
            3'd6: exp_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit cxl, input bit rel_reset);
        int n, exp_n;
        @(negedge clk);
        if (rel_reset) reset = 1'b1;
        bus.op = op; bus.A = a; bus.B = b; bus.cancel = cxl; bus.start = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs after the launch edge; the result must come from latched operands.
        bus.start = 1'b0; bus.cancel = 1'b0;
        bus.A = $urandom; bus.B = $urandom; bus.op = 3'($urandom_range(0, 7));
        model(op, a, b, cxl, exp_n);
        n = 0;
        while (bus.busy && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " busy_cycles"}, 64'(n), 64'(exp_n));
        check({tag, " hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
        check({tag, " lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
    endtask

    initial begin
        int n, lat;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        bit          rc;
        checks = 0; failures = 0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        reset = 1'b0;
        bus.A = 32'hDEAD_BEEF; bus.B = 32'h1234_5678; bus.op = 3'd5;
        bus.start = 1'b1; bus.cancel = 1'b0;
        // Reset beats a pending mthi request.
        repeat (3) @(posedge clk);
        #1;
        check("reset hi", {32'd0, bus.hi}, 64'd0);
        check("reset lo", {32'd0, bus.lo}, 64'd0);
        check("reset busy", {63'd0, bus.busy}, 64'd0);
        bus.start = 1'b0;

        // First start lands on the first edge with reset high.
        run_op("s2_multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
        run_op("s1_mult", 3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        run_op("s2_div", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("mthi", 3'd5, 32'h11, 32'd0, 1'b0, 1'b0);
        run_op("mtlo", 3'd6, 32'h22, 32'd0, 1'b0, 1'b0);
        run_op("s3_divu_zero", 3'd4, 32'd100, 32'd0, 1'b0, 1'b0);
        run_op("op0_nop", 3'd0, 32'hAAAA_AAAA, 32'd3, 1'b0, 1'b0);
        run_op("op7_nop", 3'd7, 32'hBBBB_BBBB, 32'd3, 1'b0, 1'b0);
        run_op("s6_mtlo_cancel", 3'd6, 32'h1234, 32'd0, 1'b1, 1'b0);
        run_op("s6_mtlo", 3'd6, 32'h1234, 32'd0, 1'b0, 1'b0);
        run_op("div_cancel", 3'd3, 32'd50, 32'd7, 1'b1, 1'b0);

        // Scenario 4: mthi offered at the third edge of an in-flight div is ignored.
        @(negedge clk);
        bus.op = 3'd3; bus.A = 32'd1000; bus.B = 32'hFFFF_FFF9; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        model(3'd3, 32'd1000, 32'hFFFF_FFF9, 1'b0, lat);
        n = 0;
        while (bus.busy && n < 30) begin
            if (n == 2) begin
                bus.op = 3'd5; bus.A = 32'h55; bus.start = 1'b1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            n++;
        end
        check("s4 busy_cycles", 64'(n), 64'(lat));
        check("s4 hi", {32'd0, bus.hi}, {32'd0, exp_hi});
        check("s4 lo", {32'd0, bus.lo}, {32'd0, exp_lo});

        // Scenario 5: reset at the fourth edge of a mult aborts it for good.
        @(negedge clk);
        bus.op = 3'd1; bus.A = 32'h7FFF_0001; bus.B = 32'h0003_0005; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_hi = 32'd0; exp_lo = 32'd0;
        check("s5 busy", {63'd0, bus.busy}, 64'd0);
        check("s5 hi", {32'd0, bus.hi}, 64'd0);
        check("s5 lo", {32'd0, bus.lo}, 64'd0);
        repeat (8) @(posedge clk);
        #1;
        check("s5 late hi", {32'd0, bus.hi}, 64'd0);
        check("s5 late lo", {32'd0, bus.lo}, 64'd0);

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            rc  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 28);
            if ($urandom_range(0, 15) == 0) begin
                ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
            end
            run_op("rand", rop, ra, rb, rc, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
